// File: rtl/mux_8_1.sv
// mux_8_1: single-bit 8:1 selector, out = a[sel], plus an enable-captured registered copy.
// Ports:
//   clk     rising-edge clock for the registered path
//   rst_n   asynchronous active-low reset, deasserted synchronously to clk
//   a       8-bit candidate vector, a[i] is candidate i
//   sel     3-bit index of the selected bit, all codes legal
//   en      capture strobe for the registered path
//   out     combinational a[sel], independent of clk/rst_n/en
//   out_q   registered a[sel], captured on an edge where en=1
//   out_vld high for the cycle following each accepted capture
//   sel_oh  one-hot decode of sel, only when MUX8_1_ONEHOT_EN is defined
module mux_8_1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [2:0] sel,
  input  logic       en,
  output logic       out,
  output logic       out_q,
  output logic       out_vld
`ifdef MUX8_1_ONEHOT_EN
  ,
  output logic [7:0] sel_oh
`endif
);
  logic run_q, run_d;
  logic cap_q, cap_d;
  logic vld_q, vld_d;
  assign out = a[sel];
  // run_q goes high on the first edge that samples rst_n high, so a capture
  // requested on that same release edge is dropped.
  always_comb begin
    run_d = 1'b1;
    vld_d = en & run_q;
    cap_d = vld_d ? a[sel] : cap_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cap_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      run_q <= run_d;
      cap_q <= cap_d;
      vld_q <= vld_d;
    end
  end
  assign out_q   = cap_q;
  assign out_vld = vld_q;
`ifdef MUX8_1_ONEHOT_EN
  assign sel_oh = 8'b0000_0001 << sel;
`endif
endmodule

// File: tb/tb_mux_8_1.sv
module tb_mux_8_1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [2:0] sel;
  logic       en;
  logic       out, out_q, out_vld;
`ifdef MUX8_1_ONEHOT_EN
  logic [7:0] sel_oh;
`endif
  int vectors = 0;
  int miscompares = 0;

  mux_8_1 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .sel(sel), .en(en),
    .out(out), .out_q(out_q), .out_vld(out_vld)
`ifdef MUX8_1_ONEHOT_EN
    , .sel_oh(sel_oh)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] hex_a5;
    logic [7:0] oh;
    hex_a5 = 8'hA5;
    rst_n = 1'b0; en = 1'b0; a = 8'd9; sel = 3'd2;
    #1;
    chk("reset_out_q", {7'b0, out_q}, 8'd0);
    chk("reset_out_vld", {7'b0, out_vld}, 8'd0);
    chk("a9_sel2", {7'b0, out}, 8'd0);
    sel = 3'd0; #1 chk("a9_sel0", {7'b0, out}, 8'd1);
    sel = 3'd3; #1 chk("a9_sel3", {7'b0, out}, 8'd1);
    sel = 3'd7; #1 chk("a9_sel7", {7'b0, out}, 8'd0);
    a = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1 chk($sformatf("a5_sel%0d", i), {7'b0, out}, {7'b0, hex_a5[i]});
    end
    @(negedge clk); rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("idle_vld", {7'b0, out_vld}, 8'd0);
    @(negedge clk); a = 8'h80; sel = 3'd7; en = 1'b1;
    @(posedge clk); #1;
    chk("cap80_out_q", {7'b0, out_q}, 8'd1);
    chk("cap80_vld", {7'b0, out_vld}, 8'd1);
    @(negedge clk); en = 1'b0; a = 8'h00;
    @(posedge clk); #1;
    chk("hold_out_q", {7'b0, out_q}, 8'd1);
    chk("hold_vld", {7'b0, out_vld}, 8'd0);
    chk("hold_out", {7'b0, out}, 8'd0);
    @(negedge clk); a = 8'hFF; sel = 3'd3; en = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_out_q", {7'b0, out_q}, 8'd1);
    chk("pre_rst_vld", {7'b0, out_vld}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_q", {7'b0, out_q}, 8'd0);
    chk("async_vld", {7'b0, out_vld}, 8'd0);
    chk("rst_out_ff", {7'b0, out}, 8'd1);
    a = 8'h08; #1 chk("rst_out_08_s3", {7'b0, out}, 8'd1);
    sel = 3'd2; #1 chk("rst_out_08_s2", {7'b0, out}, 8'd0);
    @(posedge clk); #1;
    chk("rst_held_vld", {7'b0, out_vld}, 8'd0);
    a = 8'hFF; sel = 3'd5; en = 1'b1;
    @(negedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_vld", {7'b0, out_vld}, 8'd0);
    chk("release_out_q", {7'b0, out_q}, 8'd0);
    @(posedge clk); #1;
    chk("post_release_out_q", {7'b0, out_q}, 8'd1);
    chk("post_release_vld", {7'b0, out_vld}, 8'd1);
    @(negedge clk); a = 8'h00;
    @(posedge clk); #1;
    chk("cont_en_out_q", {7'b0, out_q}, 8'd0);
    chk("cont_en_vld", {7'b0, out_vld}, 8'd1);
`ifdef MUX8_1_ONEHOT_EN
    oh = 8'h01;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1 chk($sformatf("onehot_sel%0d", i), sel_oh, oh);
      oh = {oh[6:0], 1'b0};
    end
`else
    oh = 8'h00;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
